// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg: shared definitions for the MEM-stage data memory and cache fill path.
//   SZ_B/SZ_H/SZ_W/SZ_D : access size encodings (1/2/4/8 bytes)
//   state_t              : transaction state {IDLE, BUSY}
//   size_bytes()         : number of bytes touched by an access of a given size
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend: combinational load-data extender.
//   i_raw      : gathered bytes, little-endian (byte k in bits 8k+7:8k)
//   i_size     : access size (SZ_B..SZ_D)
//   i_unsigned : 1 = zero-extend, 0 = sign-extend from the top loaded bit
//   o_data     : extended DATA_W result
// -----------------------------------------------------------------------------
module load_extend
    import mem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [63:0]       i_raw,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_data
);

    logic w_fill;

    always_comb begin
        o_data = '0;
        w_fill = 1'b0;
        case (i_size)
            SZ_B: begin
                w_fill = ~i_unsigned & i_raw[7];
                o_data = {{(DATA_W-8){w_fill}}, i_raw[7:0]};
            end
            SZ_H: begin
                w_fill = ~i_unsigned & i_raw[15];
                o_data = {{(DATA_W-16){w_fill}}, i_raw[15:0]};
            end
            SZ_W: begin
                w_fill = ~i_unsigned & i_raw[31];
                o_data = {{(DATA_W-32){w_fill}}, i_raw[31:0]};
            end
            default: begin
                o_data = i_raw[DATA_W-1:0];
            end
        endcase
    end

endmodule

// File: rtl/sized_data_memory.sv
// -----------------------------------------------------------------------------
// sized_data_memory: byte-addressable little-endian data memory, fixed latency.
//   i_clk, i_rst_n        : clock, async active-low reset (also clears memory)
//   i_MemRead/i_MemWrite  : load / store request, accepted when o_ready=1
//   i_addr, i_data        : byte address, store data (low 2^size bytes used)
//   i_size, i_unsigned    : access size, load zero-extension select
//   o_ready               : request can be accepted this cycle
//   o_valid               : one-cycle completion pulse, LATENCY cycles after accept
//   o_data, o_err         : extended load data / rejected access; 0 unless o_valid
// -----------------------------------------------------------------------------
module sized_data_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_MemRead,
    input  logic              i_MemWrite,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err
);

    localparam int CW     = $clog2(LATENCY) + 1;
    localparam int AW     = $clog2(DEPTH_BYTES);
    localparam bit DIRECT = (LATENCY == 1);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_size;
    logic              r_uns;
    logic              r_read;
    logic              r_write;
    logic              r_valid;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [7:0]        r_mem [DEPTH_BYTES];

    logic              w_accept;
    logic              w_fin;
    logic [ADDR_W-1:0] w_c_addr;
    logic [DATA_W-1:0] w_c_data;
    logic [1:0]        w_c_size;
    logic              w_c_uns;
    logic              w_c_read;
    logic              w_c_write;
    logic [3:0]        w_bytes;
    logic              w_misalign;
    logic              w_range;
    logic              w_bad;
    logic [AW-1:0]     w_base;
    logic [63:0]       w_raw;
    logic [DATA_W-1:0] w_ext;

    assign o_ready  = (r_state == IDLE);
    assign w_accept = o_ready & (i_MemRead | i_MemWrite);

    // With LATENCY=1 the transaction completes on its acceptance edge, so the
    // completion logic works on the live request rather than the captured one.
    // Otherwise completion fires on the edge where the counter steps 1 -> 0,
    // which makes the registered o_valid appear exactly LATENCY cycles later.
    assign w_fin     = DIRECT ? w_accept : ((r_state == BUSY) && (r_cnt == CW'(1)));
    assign w_c_addr  = DIRECT ? i_addr     : r_addr;
    assign w_c_data  = DIRECT ? i_data     : r_wdata;
    assign w_c_size  = DIRECT ? i_size     : r_size;
    assign w_c_uns   = DIRECT ? i_unsigned : r_uns;
    assign w_c_read  = DIRECT ? i_MemRead  : r_read;
    assign w_c_write = DIRECT ? i_MemWrite : r_write;

    assign w_bytes    = size_bytes(w_c_size);
    assign w_misalign = |(w_c_addr[2:0] & (w_bytes[2:0] - 3'd1));
    // One extra bit so addresses near the top of the ADDR_W space cannot wrap.
    assign w_range    = ({1'b0, w_c_addr} + (ADDR_W+1)'(w_bytes)) > (ADDR_W+1)'(DEPTH_BYTES);
    assign w_bad      = w_misalign | w_range | (w_c_read & w_c_write);
    assign w_base     = w_c_addr[AW-1:0];

    // Always gather 8 bytes; the extender keeps only the low 2^size of them.
    always_comb begin
        w_raw = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            w_raw[8*k +: 8] = r_mem[w_base + AW'(k)];
        end
    end

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .i_raw      (w_raw),
        .i_size     (w_c_size),
        .i_unsigned (w_c_uns),
        .o_data     (w_ext)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            if (w_fin) begin
                r_valid <= 1'b1;
                r_err   <= w_bad;
                r_rdata <= (w_bad || w_c_write) ? '0 : w_ext;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr  <= i_addr;
                        r_wdata <= i_data;
                        r_size  <= i_size;
                        r_uns   <= i_unsigned;
                        r_read  <= i_MemRead;
                        r_write <= i_MemWrite;
                        if (!DIRECT) begin
                            r_state <= BUSY;
                            r_cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
                r_mem[AW'(i)] <= '0;
            end
        end else if (w_fin && w_c_write && !w_bad) begin
            for (int unsigned k = 0; k < 8; k++) begin
                if (k < 32'(w_bytes)) begin
                    r_mem[w_base + AW'(k)] <= w_c_data[8*k +: 8];
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_err   = r_err;
    assign o_data  = r_rdata;

endmodule

// File: tb/tb_sized_data_memory.sv
// -----------------------------------------------------------------------------
// tb_sized_data_memory: scoreboard bench for sized_data_memory.
//   dut    : LATENCY=8 instance
//   dut_l1 : LATENCY=1 instance
// Stimulus pushes hand-computed expected responses; per-DUT monitors pop and
// compare on every o_valid, and check o_data/o_err stay 0 otherwise.
// -----------------------------------------------------------------------------
module tb_sized_data_memory;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rd0, wr0, un0, rdy0, vld0, err0;
    logic [63:0] a0, d0, q0;
    logic [1:0]  sz0;
    logic        rd1, wr1, un1, rdy1, vld1, err1;
    logic [63:0] a1, d1, q1;
    logic [1:0]  sz1;

    sized_data_memory #(.ADDR_W(64), .DATA_W(64), .DEPTH_BYTES(1024), .LATENCY(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_MemRead(rd0), .i_MemWrite(wr0),
        .i_addr(a0), .i_data(d0), .i_size(sz0), .i_unsigned(un0),
        .o_ready(rdy0), .o_valid(vld0), .o_data(q0), .o_err(err0)
    );

    sized_data_memory #(.ADDR_W(64), .DATA_W(64), .DEPTH_BYTES(1024), .LATENCY(1)) dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_MemRead(rd1), .i_MemWrite(wr1),
        .i_addr(a1), .i_data(d1), .i_size(sz1), .i_unsigned(un1),
        .o_ready(rdy1), .o_valid(vld1), .o_data(q1), .o_err(err1)
    );

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitors
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            total++;
            if (vld0) begin
                if (sb0.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid_l8: got valid with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = sb0.pop_front();
                    if (q0 !== e.data || err0 !== e.err) begin
                        bad++;
                        $display("FAIL resp_l8: got data=%h err=%b expected data=%h err=%b (t=%0t)",
                                 q0, err0, e.data, e.err, $time);
                    end
                end
            end else if (q0 !== 64'd0 || err0 !== 1'b0) begin
                bad++;
                $display("FAIL idle_zero_l8: got data=%h err=%b expected 0/0 (t=%0t)", q0, err0, $time);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            total++;
            if (vld1) begin
                if (sb1.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid_l1: got valid with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = sb1.pop_front();
                    if (q1 !== e.data || err1 !== e.err) begin
                        bad++;
                        $display("FAIL resp_l1: got data=%h err=%b expected data=%h err=%b (t=%0t)",
                                 q1, err1, e.data, e.err, $time);
                    end
                end
            end else if (q1 !== 64'd0 || err1 !== 1'b0) begin
                bad++;
                $display("FAIL idle_zero_l1: got data=%h err=%b expected 0/0 (t=%0t)", q1, err1, $time);
            end
        end
    end

    function automatic logic rdy(input int s);
        return (s != 0) ? rdy1 : rdy0;
    endfunction

    function automatic logic vld(input int s);
        return (s != 0) ? vld1 : vld0;
    endfunction

    task automatic set_in(input int s, input logic r, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [1:0] sz, input logic u);
        if (s == 0) begin
            rd0 = r; wr0 = w; a0 = a; d0 = d; sz0 = sz; un0 = u;
        end else begin
            rd1 = r; wr1 = w; a1 = a; d1 = d; sz1 = sz; un1 = u;
        end
    endtask

    // Present one request; waits for o_ready unless 'now' (caller is already
    // at a ready negedge). Returns #1 after the accepting edge.
    task automatic issue(input int s, input logic r, input logic w, input logic [63:0] a,
                         input logic [63:0] d, input logic [1:0] sz, input logic u,
                         input logic xe, input logic [63:0] xd, input bit push, input bit now);
        int n;
        exp_t e;
        n = 0;
        if (!now) begin
            do begin
                @(negedge clk);
                n++;
            end while (!rdy(s) && n < 50);
        end
        if (!rdy(s)) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got o_ready=0 expected 1 within 50 cycles (t=%0t)", $time);
        end else begin
            set_in(s, r, w, a, d, sz, u);
            e.err = xe;
            e.data = xd;
            if (push) begin
                if (s == 0) sb0.push_back(e);
                else        sb1.push_back(e);
            end
            @(posedge clk);
            #1;
            set_in(s, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
        end
    endtask

    task automatic measure(input int s, input int lat);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (vld(s)) seen = 1;
            else chk("ready_low_busy", 64'(rdy(s)), 64'd0);
        end
        chk("latency", 64'(n), 64'(lat));
        chk("ready_at_valid", 64'(rdy(s)), 64'd1);
    endtask

    task automatic wait_valid(input int s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld(s) && n < 40);
        chk("valid_seen", 64'(vld(s)), 64'd1);
    endtask

    task automatic drain(input int s);
        int n;
        n = 0;
        while (((s != 0) ? sb1.size() : sb0.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        set_in(0, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
        set_in(1, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_l8", 64'(rdy0), 64'd1);
        chk("rst_valid_l8", 64'(vld0), 64'd0);
        chk("rst_data_l8", q0, 64'd0);
        chk("rst_err_l8", 64'(err0), 64'd0);
        chk("rst_ready_l1", 64'(rdy1), 64'd1);
        chk("rst_valid_l1", 64'(vld1), 64'd0);

        // First load from reset memory, latency 8
        issue(0, 1, 0, 64'd0, 64'd0, SZ_D, 0, 0, 64'd0, 1, 0);
        measure(0, 8);

        // Store then loads of several sizes/extensions (back-to-back in valid cycles)
        issue(0, 0, 1, 64'd16, 64'h8877665544332211, SZ_D, 0, 0, 64'd0, 1, 0);
        issue(0, 1, 0, 64'd17, 64'd0, SZ_B, 0, 0, 64'h22, 1, 0);
        issue(0, 1, 0, 64'd22, 64'd0, SZ_H, 0, 0, 64'hFFFF_FFFF_FFFF_8877, 1, 0);
        issue(0, 1, 0, 64'd22, 64'd0, SZ_H, 1, 0, 64'h8877, 1, 0);
        issue(0, 1, 0, 64'd16, 64'd0, SZ_W, 0, 0, 64'h44332211, 1, 0);
        issue(0, 0, 1, 64'd19, 64'hAB, SZ_B, 0, 0, 64'd0, 1, 0);
        issue(0, 1, 0, 64'd16, 64'd0, SZ_D, 0, 0, 64'h88776655AB332211, 1, 0);

        // Request held during BUSY is ignored; new request in the valid cycle accepted
        issue(0, 1, 0, 64'd20, 64'd0, SZ_W, 0, 0, 64'hFFFF_FFFF_8877_6655, 1, 0);
        set_in(0, 1'b0, 1'b1, 64'd16, 64'd0, SZ_D, 1'b0);
        repeat (5) @(posedge clk);
        #1 set_in(0, 1'b0, 1'b0, 64'd0, 64'd0, 2'd0, 1'b0);
        wait_valid(0);
        chk("ready_in_valid_cycle", 64'(rdy0), 64'd1);
        issue(0, 1, 0, 64'd16, 64'd0, SZ_D, 0, 0, 64'h88776655AB332211, 1, 1);
        measure(0, 8);

        // Error cases and range boundaries
        issue(0, 0, 1, 64'd8, 64'h0123456789ABCDEF, SZ_D, 0, 0, 64'd0, 1, 0);
        issue(0, 1, 0, 64'd1020, 64'd0, SZ_D, 0, 1, 64'd0, 1, 0);
        issue(0, 1, 0, 64'd6, 64'd0, SZ_W, 0, 1, 64'd0, 1, 0);
        issue(0, 1, 1, 64'd8, 64'hFF, SZ_D, 0, 1, 64'd0, 1, 0);
        issue(0, 1, 0, 64'd8, 64'd0, SZ_D, 0, 0, 64'h0123456789ABCDEF, 1, 0);
        issue(0, 1, 0, 64'd1016, 64'd0, SZ_D, 0, 0, 64'd0, 1, 0);
        issue(0, 0, 1, 64'd1023, 64'h80, SZ_B, 0, 0, 64'd0, 1, 0);
        issue(0, 1, 0, 64'd1023, 64'd0, SZ_B, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 1, 0);
        issue(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, SZ_B, 0, 1, 64'd0, 1, 0);
        issue(0, 1, 0, 64'd1024, 64'd0, SZ_B, 1, 1, 64'd0, 1, 0);
        drain(0);

        // Reset during a store aborts it and clears memory
        issue(0, 0, 1, 64'd32, 64'h1111_2222_3333_4444, SZ_D, 0, 0, 64'd0, 1, 0);
        drain(0);
        issue(0, 0, 1, 64'd32, 64'h5555_6666_7777_8888, SZ_D, 0, 0, 64'd0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(rdy0), 64'd1);
        chk("post_rst_valid", 64'(vld0), 64'd0);
        repeat (10) @(negedge clk);
        issue(0, 1, 0, 64'd32, 64'd0, SZ_D, 0, 0, 64'd0, 1, 0);
        issue(0, 1, 0, 64'd16, 64'd0, SZ_D, 0, 0, 64'd0, 1, 0);
        drain(0);

        // LATENCY=1 instance
        issue(1, 0, 1, 64'd4, 64'hDEADBEEF, SZ_W, 0, 0, 64'd0, 1, 0);
        measure(1, 1);
        issue(1, 1, 0, 64'd4, 64'd0, SZ_W, 0, 0, 64'hFFFF_FFFF_DEAD_BEEF, 1, 0);
        chk("l1_ready_after_accept", 64'(rdy1), 64'd1);
        issue(1, 1, 0, 64'd4, 64'd0, SZ_W, 1, 0, 64'hDEADBEEF, 1, 0);
        issue(1, 1, 0, 64'd6, 64'd0, SZ_H, 1, 0, 64'hDEAD, 1, 0);
        issue(1, 1, 0, 64'd5, 64'd0, SZ_H, 0, 1, 64'd0, 1, 0);
        issue(1, 1, 0, 64'd5, 64'd0, SZ_B, 0, 0, 64'hFFFF_FFFF_FFFF_FFBE, 1, 0);
        measure(1, 1);
        drain(1);

        chk("sb_empty_l8", 64'(sb0.size()), 64'd0);
        chk("sb_empty_l1", 64'(sb1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
